// File: rtl/load_store_unit.sv
// Load/store unit: turns an execute-stage access into a req/ack memory transaction,
// formatting store lanes and extending load data; flags misaligned/illegal/timeout.
module load_store_unit #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [2:0]  funct3,
   input  logic [31:0] ALUResult,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        done,
   output logic        err,
   output logic        stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

   state_t      state;
   logic [7:0]  cnt;
   logic [2:0]  f3_q;
   logic [1:0]  off_q;
   logic        acc;
   logic        bad;
   logic [31:0] fwdata;
   logic [3:0]  fwstrb;
   logic [7:0]  lbyte;
   logic [15:0] lhalf;
   logic [31:0] lext;

   assign acc   = MemRead | MemWrite;
   assign stall = ((state == IDLE) & start & acc) | (state == REQ);

   always_comb begin
      bad    = MemRead & MemWrite;
      fwdata = WriteData;
      fwstrb = 4'b1111;
      case (funct3)
         3'b000: begin
            fwdata = {4{WriteData[7:0]}};
            fwstrb = 4'b0001 << ALUResult[1:0];
         end
         3'b001: begin
            fwdata = {2{WriteData[15:0]}};
            fwstrb = ALUResult[1] ? 4'b1100 : 4'b0011;
            if (ALUResult[0]) bad = 1'b1;
         end
         3'b010: if (ALUResult[1:0] != 2'b00) bad = 1'b1;
         3'b100: if (MemWrite) bad = 1'b1;
         3'b101: if (MemWrite || ALUResult[0]) bad = 1'b1;
         default: bad = 1'b1;
      endcase
   end

   // Load extraction works on the latched lane offset, not the live address.
   always_comb begin
      case (off_q)
         2'd0:    lbyte = mem_rdata[7:0];
         2'd1:    lbyte = mem_rdata[15:8];
         2'd2:    lbyte = mem_rdata[23:16];
         default: lbyte = mem_rdata[31:24];
      endcase
      lhalf = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (f3_q)
         3'b000:  lext = {{24{lbyte[7]}}, lbyte};
         3'b100:  lext = {24'd0, lbyte};
         3'b001:  lext = {{16{lhalf[15]}}, lhalf};
         3'b101:  lext = {16'd0, lhalf};
         default: lext = mem_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= 8'd0;
         f3_q      <= 3'd0;
         off_q     <= 2'd0;
         ReadData  <= 32'd0;
         done      <= 1'b0;
         err       <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 32'd0;
         mem_wdata <= 32'd0;
         mem_wstrb <= 4'd0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: if (start && acc) begin
               if (bad) begin
                  state <= DONE;
                  done  <= 1'b1;
                  err   <= 1'b1;
               end else begin
                  state     <= REQ;
                  cnt       <= 8'd0;
                  f3_q      <= funct3;
                  off_q     <= ALUResult[1:0];
                  mem_req   <= 1'b1;
                  mem_we    <= MemWrite;
                  mem_addr  <= {ALUResult[31:2], 2'b00};
                  mem_wdata <= fwdata;
                  mem_wstrb <= MemWrite ? fwstrb : 4'b0000;
               end
            end
            REQ: begin
               if (mem_ack) begin
                  state   <= DONE;
                  mem_req <= 1'b0;
                  done    <= 1'b1;
                  if (!mem_we) ReadData <= lext;
               end else if (cnt == TLAST) begin
                  state   <= DONE;
                  mem_req <= 1'b0;
                  done    <= 1'b1;
                  err     <= 1'b1;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with TIMEOUT=4; all checks sampled on the falling edge.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, MemRead, MemWrite, mem_ack;
   logic [2:0]  funct3;
   logic [31:0] ALUResult, WriteData, mem_rdata;
   logic [31:0] ReadData, mem_addr, mem_wdata;
   logic        done, err, stall, mem_req, mem_we;
   logic [3:0]  mem_wstrb;

   int checks = 0;
   int errors = 0;

   load_store_unit #(.TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .start(start), .MemRead(MemRead), .MemWrite(MemWrite),
      .funct3(funct3), .ALUResult(ALUResult), .WriteData(WriteData),
      .ReadData(ReadData), .done(done), .err(err), .stall(stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic go(input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] d);
      start = 1'b1; MemRead = rd; MemWrite = wr; funct3 = f3; ALUResult = a; WriteData = d;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'd0;
      ALUResult = 32'd0; WriteData = 32'd0; mem_rdata = 32'd0; mem_ack = 1'b0;
      cyc(); cyc();
      chk("rst_readdata", ReadData, 32'd0);
      chk("rst_ctrl", {28'd0, done, err, stall, mem_req}, 32'd0);
      chk("rst_we_strb", {27'd0, mem_we, mem_wstrb}, 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      rst = 1'b0;
      cyc();

      // SW 0x100, ack on third REQ cycle
      go(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
      #1 chk("sw_stall_start", {31'd0, stall}, 32'd1);
      cyc(); start = 1'b0;
      chk("sw_req1", {31'd0, mem_req}, 32'd1);
      chk("sw_addr", mem_addr, 32'h100);
      chk("sw_wstrb", {28'd0, mem_wstrb}, 32'hF);
      chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
      chk("sw_we", {31'd0, mem_we}, 32'd1);
      cyc(); chk("sw_req2", {30'd0, mem_req, done}, 32'b10);
      cyc(); chk("sw_req3", {31'd0, mem_req}, 32'd1);
      mem_ack = 1'b1;
      cyc(); mem_ack = 1'b0;
      chk("sw_done", {28'd0, done, err, stall, mem_req}, 32'b1000);
      cyc(); chk("sw_done_pulse", {31'd0, done}, 32'd0);

      // LB 0x203, zero-wait
      go(1'b1, 1'b0, 3'b000, 32'h203, 32'd0);
      cyc(); start = 1'b0;
      chk("lb_addr", mem_addr, 32'h200);
      chk("lb_req_rd", {26'd0, mem_req, mem_we, mem_wstrb}, 32'b100000);
      mem_ack = 1'b1; mem_rdata = 32'h80FF1234;
      cyc(); mem_ack = 1'b0;
      chk("lb_done", {30'd0, done, err}, 32'b10);
      chk("lb_data", ReadData, 32'hFFFFFF80);
      cyc();

      go(1'b1, 1'b0, 3'b100, 32'h203, 32'd0);
      cyc(); start = 1'b0; mem_ack = 1'b1;
      cyc(); mem_ack = 1'b0;
      chk("lbu_done", {30'd0, done, err}, 32'b10);
      chk("lbu_data", ReadData, 32'h00000080);
      cyc();

      // LHU / SH at 0x12
      go(1'b1, 1'b0, 3'b101, 32'h12, 32'd0);
      cyc(); start = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hBEEF0000;
      cyc(); mem_ack = 1'b0;
      chk("lhu_data", ReadData, 32'h0000BEEF);
      cyc();
      go(1'b0, 1'b1, 3'b001, 32'h12, 32'h00001234);
      cyc(); start = 1'b0;
      chk("sh_wstrb", {28'd0, mem_wstrb}, 32'hC);
      chk("sh_wdata", mem_wdata, 32'h12341234);
      chk("sh_addr", mem_addr, 32'h10);
      mem_ack = 1'b1;
      cyc(); mem_ack = 1'b0;
      chk("sh_done", {30'd0, done, err}, 32'b10);
      chk("sh_keep_rd", ReadData, 32'h0000BEEF);
      cyc();

      // Misaligned LW and read+write conflict: immediate error
      go(1'b1, 1'b0, 3'b010, 32'h102, 32'd0);
      cyc(); start = 1'b0;
      chk("lw_mis_err", {28'd0, done, err, stall, mem_req}, 32'b1100);
      chk("lw_mis_keep", ReadData, 32'h0000BEEF);
      cyc(); chk("lw_mis_idle", {30'd0, done, mem_req}, 32'd0);
      go(1'b1, 1'b1, 3'b010, 32'h100, 32'd0);
      cyc(); start = 1'b0;
      chk("rw_err", {28'd0, done, err, stall, mem_req}, 32'b1100);
      cyc(); chk("rw_idle", {30'd0, done, mem_req}, 32'd0);

      // Store with funct3 100 is illegal
      go(1'b0, 1'b1, 3'b100, 32'h0, 32'd0);
      cyc(); start = 1'b0;
      chk("sbu_err", {30'd0, done, err}, 32'b11);
      cyc();

      // start with neither read nor write is ignored
      go(1'b0, 1'b0, 3'b010, 32'h0, 32'd0);
      #1 chk("nop_stall", {31'd0, stall}, 32'd0);
      cyc(); start = 1'b0;
      chk("nop_idle", {30'd0, done, mem_req}, 32'd0);

      // Timeout: no ack
      go(1'b1, 1'b0, 3'b010, 32'h0, 32'd0);
      cyc(); start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("to_req%0d", i), {30'd0, mem_req, done}, 32'b10);
         cyc();
      end
      chk("to_done", {28'd0, done, err, stall, mem_req}, 32'b1100);
      chk("to_keep_rd", ReadData, 32'h0000BEEF);
      cyc();

      // Ack on fourth REQ cycle wins over timeout
      go(1'b1, 1'b0, 3'b010, 32'h0, 32'd0);
      cyc(); start = 1'b0;
      cyc(); cyc(); cyc();
      chk("to4_req", {31'd0, mem_req}, 32'd1);
      mem_ack = 1'b1; mem_rdata = 32'h11223344;
      cyc(); mem_ack = 1'b0;
      chk("to4_done", {30'd0, done, err}, 32'b10);
      chk("to4_data", ReadData, 32'h11223344);
      cyc();

      // Reset mid-access, late ack ignored, then fresh SB
      go(1'b1, 1'b0, 3'b010, 32'h40, 32'd0);
      cyc(); start = 1'b0;
      chk("rr_req", {31'd0, mem_req}, 32'd1);
      rst = 1'b1;
      cyc(); rst = 1'b0;
      chk("rr_after", {30'd0, mem_req, done}, 32'd0);
      chk("rr_readdata", ReadData, 32'd0);
      mem_ack = 1'b1;
      cyc(); mem_ack = 1'b0;
      chk("rr_late_ack", {30'd0, mem_req, done}, 32'd0);
      go(1'b0, 1'b1, 3'b000, 32'h1, 32'h000000AA);
      cyc(); start = 1'b0;
      chk("sb_wstrb", {28'd0, mem_wstrb}, 32'h2);
      chk("sb_wdata", mem_wdata, 32'hAAAAAAAA);
      mem_ack = 1'b1;
      cyc(); mem_ack = 1'b0;
      chk("sb_done", {30'd0, done, err}, 32'b10);
      cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit that consumes the execute stage's outputs (ALUResult as byte address, RD2 as store data) and performs the data-memory access over a req/ack handshake with variable latency. It formats store data and byte strobes, extracts and extends load data, and flags misaligned accesses, illegal widths and memory timeouts. It sits between the ALU and the writeback mux, and stalls the core while an access is outstanding.

## Interface
- TIMEOUT, 16: max cycles to wait for mem_ack in REQ before aborting; legal range 1..255.
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request from execute; sampled only in IDLE
- MemRead  in  1  load request
- MemWrite  in  1  store request
- funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- ALUResult  in  32  byte address
- WriteData  in  32  store data (RD2)
- ReadData  out  32  extended load result, valid when done=1
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; 1 = misaligned, illegal or timeout
- stall  out  1  core must hold PC/inputs
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  1 = write
- mem_addr  out  32  word address, {ALUResult[31:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_wstrb  out  4  byte enables, 0000 for reads
- mem_rdata  in  32  read data, valid with mem_ack
- mem_ack  in  1  one-cycle acknowledge

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE: on start with exactly one of MemRead/MemWrite: if legal and aligned -> REQ, latch address, funct3, formatted wdata, wstrb, we; otherwise -> DONE with err=1, no memory access. start with neither Read nor Write: ignored, stays IDLE.
- Error conditions: MemRead and MemWrite both high; funct3 in {011,110,111}; store with funct3 100/101; H/HU with addr[0]=1; W with addr[1:0]!=00.
- REQ: mem_req=1, outputs stable. mem_ack -> capture mem_rdata, -> DONE, err=0. No ack with timeout counter == TIMEOUT-1 -> DONE, err=1. Ack and timeout in the same cycle: ack wins.
- DONE: done=1 for exactly one cycle, then IDLE.
- Store formatting: B: wdata={4{WriteData[7:0]}}, wstrb=0001<<addr[1:0]; H: wdata={2{WriteData[15:0]}}, wstrb=0011 (addr[1]=0) or 1100; W: wdata=WriteData, wstrb=1111.
- Load extraction from lane addr[1:0]: B sign-extend byte, BU zero-extend, H/HU half at addr[1], W whole word.
- ReadData holds its last value until the next successful load; 0 after reset; not updated by stores or errors.
- start ignored outside IDLE.

## Timing
- Reset values: ReadData=0, done=0, err=0, stall=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0; FSM=IDLE, timeout counter=0.
- stall = (IDLE & start & (MemRead|MemWrite)) | REQ; combinational, so the core holds from the start cycle. stall=0 in DONE.
- mem_req is registered: asserted the cycle after start is accepted.
- Minimum latency, zero-wait memory (ack in first REQ cycle): start at cycle N, mem_req N+1, done N+2.
- Error path: start at N -> done/err at N+1, mem_req never asserted.
- Timeout counter clears on REQ entry and increments each REQ cycle without ack.
- rst mid-access: FSM->IDLE at that edge, mem_req=0 next cycle, no done pulse; a late mem_ack in IDLE is ignored.

## Test plan
- SW addr 0x100, data 0xDEADBEEF, ack after 3 cycles -> mem_addr 0x100, wstrb 1111, wdata 0xDEADBEEF, mem_req high 3 cycles, done=1 err=0, stall low in DONE.
- LB addr 0x203, mem_rdata 0x80FF1234, ack immediate -> mem_addr 0x200, ReadData 0xFFFFFF80; repeat with LBU -> 0x00000080; done at N+2.
- LHU addr 0x12, mem_rdata 0xBEEF0000 -> ReadData 0x0000BEEF; SH addr 0x12 data 0x00001234 -> wstrb 1100, wdata 0x12341234.
- LW addr 0x102, and start with MemRead=MemWrite=1 -> done at N+1 with err=1, mem_req never high, ReadData unchanged.
- TIMEOUT=4, LW with no ack -> mem_req high exactly 4 cycles, then done=1 err=1; repeat with ack on 4th REQ cycle -> err=0.
- rst asserted during REQ -> mem_req 0 next cycle, no done, then a fresh SB addr 0x1 data 0xAA -> wstrb 0010, wdata 0xAAAAAAAA.
